// File: rtl/nand_pkg.sv
// Shared widths, row-status codes and FSM state encodings for the NAND page write feeder.
package nand_pkg;
    localparam int unsigned ROW_W = 24;
    localparam int unsigned CNT_W = 14;

    localparam logic [1:0] ROW_UNCHK = 2'd0;
    localparam logic [1:0] ROW_GOOD  = 2'd1;
    localparam logic [1:0] ROW_BAD   = 2'd2;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_ARM   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_CHECK = 3'd3;
    localparam logic [ST_W-1:0] ST_SKIP  = 3'd4;
    localparam logic [ST_W-1:0] ST_NEXT  = 3'd5;
    localparam logic [ST_W-1:0] ST_ERR   = 3'd6;
    localparam logic [ST_W-1:0] ST_FULL  = 3'd7;
endpackage

// File: rtl/nand_pingpong_buf.sv
// Two-bank page buffer: fills one bank from the byte stream while the other is read out by the controller.
module nand_pingpong_buf
    import nand_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = 2048,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             flush,
    input  logic             release_bank,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             rd_ready,
    output logic             wr_blocked,
    output logic             padding
);
    localparam int unsigned AW = $clog2(PAGE_BYTES);

    logic [7:0]    mem [2*PAGE_BYTES];
    logic [AW-1:0] wr_ptr;
    logic          wr_bank;
    logic          rd_bank;
    logic          pad_q;
    logic [1:0]    ready_q;
    logic          do_wr;
    logic          wr_last;
    logic          oob_c;
    logic [7:0]    wdat;

    assign do_wr      = wr_en || pad_q;
    assign wdat       = pad_q ? 8'hFF : wr_data;
    assign wr_last    = (wr_ptr == AW'(PAGE_BYTES - 1));
    assign oob_c      = (rd_idx >= CNT_W'(PAGE_BYTES));
    assign rd_ready   = ready_q[rd_bank];
    assign wr_blocked = ready_q[wr_bank];
    assign padding    = pad_q;

    // Fill pointer, bank flags and flush padding; a flush landing on the last byte has nothing left to pad.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            pad_q   <= 1'b0;
            ready_q <= '0;
        end else begin
            if (do_wr) begin
                if (wr_last) begin
                    wr_ptr           <= '0;
                    wr_bank          <= ~wr_bank;
                    ready_q[wr_bank] <= 1'b1;
                    pad_q            <= 1'b0;
                end else begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
            if (flush && !pad_q && (wr_ptr != '0) && !(do_wr && wr_last)) begin
                pad_q <= 1'b1;
            end
            if (release_bank) begin
                ready_q[rd_bank] <= 1'b0;
                rd_bank          <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[{wr_bank, wr_ptr}] <= wdat;
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_comb_rd
            assign rd_data = oob_c ? 8'hFF : mem[{rd_bank, rd_idx[AW-1:0]}];
        end else begin : g_reg_rd
            logic [7:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= oob_c ? 8'hFF : mem[{rd_bank, rd_idx[AW-1:0]}];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate
endmodule

// File: rtl/nand_page_write_feeder.sv
// Packs a byte stream into pages, hands them to the NAND controller and walks the row address past bad blocks.
module nand_page_write_feeder
    import nand_pkg::*;
#(
    parameter int unsigned      PAGE_BYTES    = 2048,
    parameter int unsigned      PAGES_PER_BLK = 64,
    parameter logic [ROW_W-1:0] FIRST_ROW     = 24'h0,
    parameter logic [ROW_W-1:0] LAST_ROW      = 24'h3FFFF,
    parameter int unsigned      MAX_RETRY     = 4,
    parameter int unsigned      RD_LATENCY    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             start_row_load,
    input  logic [ROW_W-1:0] start_row,
    input  logic             flush,
    output logic             en_write_page,
    input  logic             end_write_page,
    input  logic [CNT_W-1:0] write_data_cnt,
    output logic [7:0]       write_data,
    output logic [ROW_W-1:0] write_addr_row,
    input  logic [1:0]       write_addr_row_error,
    input  logic [1:0]       write_success,
    input  logic             nandflash_busy_Noresponse,
    output logic [ROW_W-1:0] pages_written,
    output logic             mem_full,
    output logic             err_retry,
    output logic             err_timeout
);
    localparam int unsigned      RT_W    = $clog2(MAX_RETRY + 1);
    localparam logic [ROW_W:0]   LAST_X  = {1'b0, LAST_ROW};
    localparam logic [ROW_W:0]   PG_MASK = (ROW_W + 1)'(PAGES_PER_BLK - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] pages_q, pages_d;
    logic [RT_W-1:0]  retry_q, retry_d;
    logic             en_q, en_d;
    logic             full_q, full_d;
    logic             eretry_q, eretry_d;
    logic             etime_q, etime_d;
    logic             bad_q, bad_d;
    logic             past_q, past_d;
    logic             release_c;
    logic             rd_ready;
    logic             wr_blocked;
    logic             padding;
    logic [ROW_W:0]   row_inc;
    logic [ROW_W:0]   row_skip;
    logic [RT_W-1:0]  retry_inc;

    assign row_inc   = {1'b0, row_q} + (ROW_W + 1)'(1);
    assign row_skip  = ({1'b0, row_q} | PG_MASK) + (ROW_W + 1)'(1);
    assign retry_inc = retry_q + RT_W'(1);

    assign in_ready       = !wr_blocked && !padding && !full_q;
    assign en_write_page  = en_q;
    assign write_addr_row = row_q;
    assign pages_written  = pages_q;
    assign mem_full       = full_q;
    assign err_retry      = eretry_q;
    assign err_timeout    = etime_q;

    nand_pingpong_buf #(
        .PAGE_BYTES (PAGE_BYTES),
        .RD_LATENCY (RD_LATENCY)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (in_valid && in_ready),
        .wr_data      (in_data),
        .flush        (flush),
        .release_bank (release_c),
        .rd_idx       (write_data_cnt),
        .rd_data      (write_data),
        .rd_ready     (rd_ready),
        .wr_blocked   (wr_blocked),
        .padding      (padding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= FIRST_ROW;
            pages_q  <= '0;
            retry_q  <= '0;
            en_q     <= 1'b0;
            full_q   <= 1'b0;
            eretry_q <= 1'b0;
            etime_q  <= 1'b0;
            bad_q    <= 1'b0;
            past_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pages_q  <= pages_d;
            retry_q  <= retry_d;
            en_q     <= en_d;
            full_q   <= full_d;
            eretry_q <= eretry_d;
            etime_q  <= etime_d;
            bad_q    <= bad_d;
            past_q   <= past_d;
        end
    end

    // Page handshake sequencing; the programming verdict is latched with end_write_page and acted on in CHECK.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pages_d   = pages_q;
        retry_d   = retry_q;
        en_d      = en_q;
        full_d    = full_q;
        eretry_d  = eretry_q;
        etime_d   = etime_q;
        bad_d     = bad_q;
        past_d    = past_q;
        release_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_row_load) begin
                    row_d = start_row;
                end else if (rd_ready && !full_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                en_d    = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (end_write_page) begin
                    bad_d   = (write_addr_row_error == ROW_BAD) || (write_success == 2'd0);
                    en_d    = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad_q) begin
                    state_d = ST_SKIP;
                end else begin
                    release_c = 1'b1;
                    pages_d   = pages_q + ROW_W'(1);
                    row_d     = row_inc[ROW_W-1:0];
                    past_d    = (row_inc > LAST_X);
                    state_d   = ST_NEXT;
                end
            end
            ST_SKIP: begin
                retry_d = retry_inc;
                row_d   = row_skip[ROW_W-1:0];
                if (retry_inc == RT_W'(MAX_RETRY)) begin
                    eretry_d = 1'b1;
                    state_d  = ST_ERR;
                end else if (row_skip > LAST_X) begin
                    full_d  = 1'b1;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_NEXT: begin
                retry_d = '0;
                if (past_q) begin
                    full_d  = 1'b1;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR, ST_FULL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (nandflash_busy_Noresponse) begin
            etime_d = 1'b1;
            en_d    = 1'b0;
            if (state_q != ST_FULL) begin
                state_d = ST_ERR;
            end
        end
    end
endmodule

// File: tb/tb_nand_page_write_feeder.sv
// Self-checking bench: byte-stream scoreboard against a controller model, plus read-port vector table.
module tb_nand_page_write_feeder;
    import nand_pkg::*;

    localparam int unsigned PB   = 2048;
    localparam logic [23:0] LAST = 24'h3FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        start_row_load;
    logic [23:0] start_row;
    logic        flush;
    logic        en_write_page;
    logic        end_write_page;
    logic [13:0] write_data_cnt;
    logic [7:0]  write_data;
    logic [23:0] write_addr_row;
    logic [1:0]  write_addr_row_error;
    logic [1:0]  write_success;
    logic        nandflash_busy_Noresponse;
    logic [23:0] pages_written;
    logic        mem_full;
    logic        err_retry;
    logic        err_timeout;

    always #5 clk = ~clk;

    nand_page_write_feeder dut (
        .clk                       (clk),
        .rst                       (rst),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_data                   (in_data),
        .start_row_load            (start_row_load),
        .start_row                 (start_row),
        .flush                     (flush),
        .en_write_page             (en_write_page),
        .end_write_page            (end_write_page),
        .write_data_cnt            (write_data_cnt),
        .write_data                (write_data),
        .write_addr_row            (write_addr_row),
        .write_addr_row_error      (write_addr_row_error),
        .write_success             (write_success),
        .nandflash_busy_Noresponse (nandflash_busy_Noresponse),
        .pages_written             (pages_written),
        .mem_full                  (mem_full),
        .err_retry                 (err_retry),
        .err_timeout               (err_timeout)
    );

    typedef struct {
        logic [13:0] cnt;
        logic [7:0]  exp;
    } rd_vec_t;

    int         nvec = 0;
    int         nerr = 0;
    int         seq  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] cap [PB];
    rd_vec_t    rtab [9];

    function automatic logic [7:0] pat(input int s);
        return 8'(s * 37 + (s >> 8) * 11 + 5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        start_row_load = 1'b0;
        start_row = 24'h0;
        flush = 1'b0;
        end_write_page = 1'b0;
        write_data_cnt = 14'h0;
        write_addr_row_error = 2'd0;
        write_success = 2'd0;
        nandflash_busy_Noresponse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        seq = 0;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_en"},       32'(en_write_page),  0);
        chk({nm, "_row"},      32'(write_addr_row), 0);
        chk({nm, "_in_ready"}, 32'(in_ready),       1);
        chk({nm, "_pages"},    32'(pages_written),  0);
        chk({nm, "_full"},     32'(mem_full),       0);
        chk({nm, "_eretry"},   32'(err_retry),      0);
        chk({nm, "_etime"},    32'(err_timeout),    0);
        chk({nm, "_wdata"},    32'(write_data),     0);
    endtask

    task automatic send_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            in_data  = pat(seq);
            in_valid = 1'b1;
            exp_q.push_back(pat(seq));
            seq++;
            while (!in_ready && t < 20000) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!in_ready) begin
                nvec++;
                nerr++;
                $display("FAIL stream_stall: in_ready low for %0d cycles at byte %0d, required 1", t, k);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_en(input string nm, output bit ok);
        int t;
        t = 0;
        while (!en_write_page && t < 30000) begin
            @(posedge clk);
            #1;
            t++;
        end
        ok = en_write_page;
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL %s_en: en_write_page stayed 0 for %0d cycles, required 1", nm, t);
        end
    endtask

    task automatic cmp_page(input string nm, input bit pop);
        int bad;
        int first;
        bad = 0;
        first = 0;
        nvec++;
        if (exp_q.size() < PB) begin
            nerr++;
            $display("FAIL %s_data: scoreboard holds %0d bytes, required %0d", nm, exp_q.size(), PB);
            return;
        end
        for (int i = 0; i < PB; i++) begin
            if (cap[i] !== exp_q[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        if (bad != 0) begin
            nerr++;
            $display("FAIL %s_data: %0d bytes differ, first at %0d got 0x%0h expected 0x%0h",
                     nm, bad, first, cap[first], exp_q[first]);
        end
        if (pop) begin
            repeat (PB) void'(exp_q.pop_front());
        end
    endtask

    task automatic ctrl_page(input string nm, input logic [23:0] exp_row, input logic [1:0] err,
                             input logic [1:0] succ, input bit do_read, input bit pop, input bit do_tab);
        bit ok;
        wait_en(nm, ok);
        if (!ok) return;
        chk({nm, "_row"}, 32'(write_addr_row), 32'(exp_row));
        if (do_read) begin
            for (int i = 0; i < PB; i++) begin
                write_data_cnt = 14'(i);
                @(posedge clk);
                #1;
                cap[i] = write_data;
            end
            cmp_page(nm, pop);
        end
        if (do_tab) begin
            for (int i = 0; i < 9; i++) begin
                write_data_cnt = rtab[i].cnt;
                @(posedge clk);
                #1;
                chk($sformatf("rd_tab%0d_idx%0d", i, rtab[i].cnt), 32'(write_data), 32'(rtab[i].exp));
            end
        end
        write_addr_row_error = err;
        write_success = succ;
        end_write_page = 1'b1;
        @(posedge clk);
        #1;
        end_write_page = 1'b0;
        chk({nm, "_en_low"}, 32'(en_write_page), 0);
    endtask

    task automatic watch_no_en(input string nm, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (en_write_page) seen++;
        end
        chk(nm, 32'(seen), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rtab[0] = '{14'd0,     pat(0)};
        rtab[1] = '{14'd1,     pat(1)};
        rtab[2] = '{14'd99,    pat(99)};
        rtab[3] = '{14'd100,   8'hFF};
        rtab[4] = '{14'd101,   8'hFF};
        rtab[5] = '{14'd2047,  8'hFF};
        rtab[6] = '{14'd2048,  8'hFF};
        rtab[7] = '{14'd3000,  8'hFF};
        rtab[8] = '{14'd16383, 8'hFF};

        // Reset state
        do_reset();
        check_reset("rst");

        // Two good pages streamed back to back
        fork
            send_bytes(2 * PB);
            begin
                ctrl_page("p0", 24'h0, ROW_GOOD, 2'd1, 1'b1, 1'b1, 1'b0);
                ctrl_page("p1", 24'h1, ROW_GOOD, 2'd1, 1'b1, 1'b1, 1'b0);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("p_pages", 32'(pages_written), 2);
        chk("p_row", 32'(write_addr_row), 2);

        // Bad block at row 0, retried at next block, then retry counter cleared
        do_reset();
        fork
            send_bytes(PB);
            begin
                ctrl_page("bb0", 24'h0,  ROW_BAD,  2'd1, 1'b1, 1'b0, 1'b0);
                ctrl_page("bb1", 24'h40, ROW_GOOD, 2'd1, 1'b1, 1'b1, 1'b0);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bb_pages", 32'(pages_written), 1);
        chk("bb_row", 32'(write_addr_row), 32'h41);
        fork
            send_bytes(PB);
            begin
                ctrl_page("rc0", 24'h41,  ROW_UNCHK, 2'd0, 1'b0, 1'b0, 1'b0);
                ctrl_page("rc1", 24'h80,  ROW_UNCHK, 2'd0, 1'b0, 1'b0, 1'b0);
                ctrl_page("rc2", 24'hC0,  ROW_UNCHK, 2'd0, 1'b0, 1'b0, 1'b0);
                ctrl_page("rc3", 24'h100, ROW_GOOD,  2'd1, 1'b1, 1'b1, 1'b0);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("rc_eretry", 32'(err_retry), 0);
        chk("rc_pages", 32'(pages_written), 2);

        // Four programming failures in a row
        do_reset();
        fork
            send_bytes(2 * PB);
            begin
                for (int k = 0; k < 4; k++) begin
                    ctrl_page($sformatf("rt%0d", k), 24'(k * 64), ROW_GOOD, 2'd0, 1'b0, 1'b0, 1'b0);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("rt_eretry", 32'(err_retry), 1);
        chk("rt_en", 32'(en_write_page), 0);
        chk("rt_in_ready", 32'(in_ready), 0);
        chk("rt_row", 32'(write_addr_row), 32'h100);
        watch_no_en("rt_stuck", 50);

        // Last usable row
        do_reset();
        start_row = LAST;
        start_row_load = 1'b1;
        @(posedge clk);
        #1;
        start_row_load = 1'b0;
        chk("lr_load", 32'(write_addr_row), 32'(LAST));
        fork
            send_bytes(PB);
            ctrl_page("lr", LAST, ROW_GOOD, 2'd1, 1'b1, 1'b1, 1'b0);
        join
        repeat (4) @(posedge clk);
        #1;
        chk("lr_full", 32'(mem_full), 1);
        chk("lr_in_ready", 32'(in_ready), 0);
        chk("lr_pages", 32'(pages_written), 1);
        watch_no_en("lr_no_en", 100);

        // Flush: empty bank ignored, partial bank padded with 0xFF
        do_reset();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_empty_in_ready", 32'(in_ready), 1);
        send_bytes(100);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_pad_in_ready", 32'(in_ready), 0);
        repeat (PB - 100) exp_q.push_back(8'hFF);
        ctrl_page("fl", 24'h0, ROW_GOOD, 2'd1, 1'b1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("fl_pages", 32'(pages_written), 1);

        // Controller timeout mid-WAIT, then reset recovery
        do_reset();
        fork
            send_bytes(PB);
            begin
                wait_en("to", ok);
                if (ok) begin
                    repeat (5) @(posedge clk);
                    #1;
                    nandflash_busy_Noresponse = 1'b1;
                    @(posedge clk);
                    #1;
                    nandflash_busy_Noresponse = 1'b0;
                    chk("to_en", 32'(en_write_page), 0);
                    chk("to_etime", 32'(err_timeout), 1);
                end
            end
        join
        watch_no_en("to_stuck", 20);
        do_reset();
        check_reset("rst2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
